free_list: RTL

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list_pkg.sv | 10 +
 rtl/free_list_compact.sv | 19 +
 rtl/free_list.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/free_list_pkg.sv
// Shared constants and types for the physical-register free list.
package free_list_pkg;

    localparam int unsigned N_PHYS = 32;
    localparam int unsigned N_ARCH = 8;
    localparam int unsigned P_W    = 5;

    typedef logic [P_W-1:0] preg_t;

endpackage

// File: rtl/free_list_compact.sv
// Three-slot popcount and prefix-offset generator. Turns a sparse x/y/z request
// vector into the number of active slots and each slot's offset into a
// compacted run, so the alloc and free sides can both address consecutive
// FIFO entries.
module free_list_compact (
    input  logic [2:0] req_i,   // bit 0 = slot x, bit 1 = slot y, bit 2 = slot z
    output logic [1:0] cnt_o,
    output logic [1:0] off_y_o,
    output logic [1:0] off_z_o
);

    // Prefix sums over the request bits in x, y, z order.
    always_comb begin
        off_y_o = {1'b0, req_i[0]};
        off_z_o = {1'b0, req_i[0]} + {1'b0, req_i[1]};
        cnt_o   = off_z_o + {1'b0, req_i[2]};
    end

endmodule

// File: rtl/free_list.sv
// Physical-register free list for a 3-wide rename/retire pipeline.
// Circular FIFO with head (allocate), tail (free) and commit_head (recovery
// point) pointers. Optional feature: define FREE_LIST_ERR_EN to add a sticky
// err output flagging over-free or over-allocation.
module free_list #(
    parameter int unsigned N_PHYS = 32,
    parameter int unsigned N_ARCH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       freeze_front,
    input  logic       alloc_x,
    input  logic       alloc_y,
    input  logic       alloc_z,
    output logic [4:0] Pw_new_x,
    output logic [4:0] Pw_new_y,
    output logic [4:0] Pw_new_z,
    output logic       full_PRF,
    output logic [5:0] free_cnt,
    input  logic       RegWr_x,
    input  logic       RegWr_y,
    input  logic       RegWr_z,
    input  logic       exp_x,
    input  logic       exp_y,
    input  logic       exp_z,
    input  logic [4:0] Pw_retire_x,
    input  logic [4:0] Pw_retire_y,
    input  logic [4:0] Pw_retire_z
`ifdef FREE_LIST_ERR_EN
    ,
    output logic       err
`endif
);
    import free_list_pkg::*;

    localparam int unsigned PTR_W     = $clog2(N_PHYS);
    localparam int unsigned FREE_INIT = N_PHYS - N_ARCH;

    typedef logic [PTR_W-1:0] ptr_t;

    preg_t      fifo_q [N_PHYS];
    preg_t      fifo_d [N_PHYS];
    ptr_t       head_q, head_d;
    ptr_t       tail_q, tail_d;
    ptr_t       commit_q, commit_d;
    logic [5:0] count_q, count_d;

    logic [2:0] alloc_v, free_v;
    logic [1:0] nalloc, a_off_y, a_off_z;
    logic [1:0] nfree, f_off_y, f_off_z;
    logic [1:0] nalloc_eff;
    logic       alloc_fire;

    // Modular pointer add; offsets never exceed 3 so one subtraction suffices.
    function automatic ptr_t ptr_add(ptr_t p, logic [1:0] o);
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W+1)'(o);
        if (s >= (PTR_W+1)'(N_PHYS)) begin
            s = s - (PTR_W+1)'(N_PHYS);
        end
        return s[PTR_W-1:0];
    endfunction

    assign alloc_v = {alloc_z, alloc_y, alloc_x};
    assign free_v  = {RegWr_z & ~exp_z, RegWr_y & ~exp_y, RegWr_x & ~exp_x};

    free_list_compact u_alloc_compact (
        .req_i   (alloc_v),
        .cnt_o   (nalloc),
        .off_y_o (a_off_y),
        .off_z_o (a_off_z)
    );

    free_list_compact u_free_compact (
        .req_i   (free_v),
        .cnt_o   (nfree),
        .off_y_o (f_off_y),
        .off_z_o (f_off_z)
    );

    // Status and allocation outputs, combinational from registered state.
    always_comb begin
        full_PRF   = (count_q < 6'd3);
        free_cnt   = count_q;
        alloc_fire = ~flush & ~freeze_front & ~full_PRF;
        nalloc_eff = alloc_fire ? nalloc : 2'd0;
        Pw_new_x   = fifo_q[head_q];
        Pw_new_y   = fifo_q[ptr_add(head_q, a_off_y)];
        Pw_new_z   = fifo_q[ptr_add(head_q, a_off_z)];
    end

    // Next state: freed regs land at tail; flush rewinds head to the commit point.
    always_comb begin
        fifo_d = fifo_q;
        if (free_v[0]) fifo_d[tail_q] = Pw_retire_x;
        if (free_v[1]) fifo_d[ptr_add(tail_q, f_off_y)] = Pw_retire_y;
        if (free_v[2]) fifo_d[ptr_add(tail_q, f_off_z)] = Pw_retire_z;
        tail_d   = ptr_add(tail_q, nfree);
        commit_d = ptr_add(commit_q, nfree);
        if (flush) begin
            head_d  = commit_d;
            count_d = 6'(FREE_INIT);
        end else begin
            head_d  = ptr_add(head_q, nalloc_eff);
            count_d = count_q - {4'b0, nalloc_eff} + {4'b0, nfree};
        end
    end

    // State registers; reset loads regs N_ARCH.. as the initial free pool.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_PHYS; i++) begin
                fifo_q[i] <= (unsigned'(i) < FREE_INIT) ? preg_t'(unsigned'(i) + N_ARCH) : '0;
            end
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= ptr_t'(FREE_INIT);
            count_q  <= 6'(FREE_INIT);
        end else begin
            fifo_q   <= fifo_d;
            head_q   <= head_d;
            commit_q <= commit_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

`ifdef FREE_LIST_ERR_EN
    logic err_q, err_d;

    // Sticky flag: freeing beyond the pool size or allocating more than held.
    always_comb begin
        err_d = err_q;
        if (({1'b0, count_q} + {5'b0, nfree}) > 7'(FREE_INIT)) err_d = 1'b1;
        if (alloc_fire && (count_q < {4'b0, nalloc})) err_d = 1'b1;
    end

    // Error register, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule
